// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Iterative SLL/SRL/SRA unit that shifts at most STEP bit
//               positions per clock, with valid/ready request and result ports.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [1:0]         req_op,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               busy
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_sra = 2'b11;

    localparam logic [SHAMT_W:0] c_step = (SHAMT_W + 1)'(STEP);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;

    logic [SHAMT_W:0]   w_n;
    logic [WIDTH-1:0]   w_shifted;

    // Step size is min(remaining, STEP); one extra bit lets STEP equal WIDTH.
    assign w_n = ({1'b0, rem_q} < c_step) ? {1'b0, rem_q} : c_step;

    // Small mux over the STEP+1 fixed shifts instead of a full barrel shifter.
    always_comb begin
        w_shifted = acc_q;
        for (int k = 1; k <= STEP; k++) begin
            if (w_n == (SHAMT_W + 1)'(k)) begin
                if (op_q == c_op_sll) begin
                    w_shifted = acc_q << k;
                end else if (op_q == c_op_sra) begin
                    w_shifted = $signed(acc_q) >>> k;
                end else begin
                    w_shifted = acc_q >> k;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        acc_d   = req_a;
                        rem_d   = req_shamt;
                        op_d    = req_op;
                        state_d = (req_shamt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_d = w_shifted;
                    rem_d = rem_q - w_n[SHAMT_W-1:0];
                    if ({1'b0, rem_q} == w_n) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_data  = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Directed vector bench for shift_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [4:0]  req_shamt;
    logic [1:0]  req_op;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_shamt (req_shamt),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, measure latency, check the result, then handshake it.
    task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op,
                          input logic [31:0] exp, input int lat, input string name);
        int edges;
        @(negedge clk);
        check({name, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_shamt = sh;
        req_op    = op;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = 1;
        check({name, " ready_after_accept"}, 32'(req_ready), 32'd0);
        while (!res_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, " latency"}, 32'(edges), 32'(lat));
        check({name, " data"}, res_data, exp);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({name, " valid_dropped"}, 32'(res_valid), 32'd0);
        check({name, " idle_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          edges;
        total = 0;
        bad   = 0;

        vecs[0] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 9};
        vecs[1] = '{32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 9};
        vecs[2] = '{32'h7000_0000, 5'd4,  2'b11, 32'h0700_0000, 2};
        vecs[3] = '{32'h0000_00FF, 5'd4,  2'b01, 32'h0000_000F, 2};
        vecs[4] = '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1};
        vecs[5] = '{32'hF000_0000, 5'd8,  2'b10, 32'h00F0_0000, 3};
        vecs[6] = '{32'h8000_0010, 5'd5,  2'b11, 32'hFC00_0000, 3};
        vecs[7] = '{32'hDEAD_BEEF, 5'd16, 2'b00, 32'hBEEF_0000, 5};
        vecs[8] = '{32'h0000_000F, 5'd3,  2'b00, 32'h0000_0078, 2};
        vecs[9] = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 9};

        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_shamt = '0;
        req_op    = '0;
        res_ready = 1'b0;
        #12;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_data",  res_data,       32'd0);
        check("rst busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].shamt, vecs[i].op, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        for (int s = 0; s < 32; s++) begin
            run_op(32'h0000_0001, 5'(s), 2'b00, 32'h1 << s,
                   (s == 0) ? 1 : 1 + (s + 3) / 4, $sformatf("sll_sweep%0d", s));
        end

        // Backpressure: result held 5 cycles with another request pending.
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'h0000_0001; req_shamt = 5'd1; req_op = 2'b00;
        @(posedge clk); #1;
        req_a = 32'h0000_0100; req_shamt = 5'd8; req_op = 2'b01;
        @(posedge clk); #1;
        check("bp valid", 32'(res_valid), 32'd1);
        held = res_data;
        check("bp data", held, 32'h0000_0002);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp hold valid", 32'(res_valid), 32'd1);
            check("bp hold data",  res_data,       32'h0000_0002);
            check("bp no accept",  32'(req_ready), 32'd0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp handshake idle",  32'(req_ready), 32'd1);
        check("bp handshake valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp next accepted", 32'(busy), 32'd1);
        edges = 0;
        while (!res_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("bp next latency", 32'(edges), 32'd2);
        check("bp next data", res_data, 32'h0000_0001);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Flush on the third edge of a 20-bit SLL.
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'h0000_0001; req_shamt = 5'd20; req_op = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("flush pre valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush idle",  32'(req_ready), 32'd1);
        check("flush busy",  32'(busy),      32'd0);
        check("flush valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'h0000_0055; req_shamt = 5'd1; req_op = 2'b00;
        @(posedge clk); #1;
        check("flush blocks accept", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("flush never valid", 32'(res_valid), 32'd0);
        end
        run_op(32'h0000_00FF, 5'd4, 2'b01, 32'h0000_000F, 2, "post_flush");

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'h0000_000F; req_shamt = 5'd20; req_op = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid rst busy before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid rst ready", 32'(req_ready), 32'd1);
        check("mid rst valid", 32'(res_valid), 32'd0);
        check("mid rst data",  res_data,       32'd0);
        check("mid rst busy",  32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'h0000_000F, 5'd20, 2'b00, 32'h00F0_0000, 6, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
